// File: rtl/spi_master_12_if.sv
// Bus bundle between the SPI master, its system-side controller and the 12-bit slave.
// The master modport is the view taken by spi_master_12. The slave modport is the view taken by the far side.
interface spi_master_12_if #(
  parameter int m = 12
);
  logic         ST;
  logic [m-1:0] DI;
  logic         MISO;
  logic         SCLK;
  logic         MOSI;
  logic         LOAD;
  logic [m-1:0] MRX_DAT;
  logic         BUSY;
  logic         DONE;

  modport master (
    input  ST, DI, MISO,
    output SCLK, MOSI, LOAD, MRX_DAT, BUSY, DONE
  );

  modport slave (
    output ST, DI, MISO,
    input  SCLK, MOSI, LOAD, MRX_DAT, BUSY, DONE
  );
endinterface

// File: rtl/spi_master_12.sv
// SPI master for the 12-bit slave shifter: m data SCLK periods then one LOAD period per frame.
// Receives the reply word on SCLK falling edges. All outputs are registered.
module spi_master_12 #(
  parameter int m   = 12,
  parameter int DIV = 4
) (
  input  logic             clk,
  input  logic             clr,
  spi_master_12_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LDP   = 2'd2
  } state_t;

  localparam int DW = $clog2(DIV) + 1;
  localparam int BW = $clog2(m + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(m - 1);

  state_t        state_r;
  logic [DW-1:0] div_cnt_r;
  logic [BW-1:0] bit_cnt_r;
  logic [m-1:0]  sr_tx_r;
  logic [m-1:0]  sr_rx_r;
  logic          phase_end_s;

  assign phase_end_s = (div_cnt_r == DIV_LAST);

  // Frame sequencer: SCLK phase timing, shift registers and all registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= IDLE;
      div_cnt_r   <= '0;
      bit_cnt_r   <= '0;
      sr_tx_r     <= '0;
      sr_rx_r     <= '0;
      bus.SCLK    <= 1'b0;
      bus.MOSI    <= 1'b0;
      bus.LOAD    <= 1'b0;
      bus.MRX_DAT <= '0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      case (state_r)
        IDLE: begin
          div_cnt_r <= '0;
          bit_cnt_r <= '0;
          bus.SCLK  <= 1'b0;
          if (bus.ST) begin
            sr_tx_r  <= bus.DI;
            bus.MOSI <= bus.DI[m-1];
            bus.BUSY <= 1'b1;
            state_r  <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end

        SHIFT: begin
          if (phase_end_s) begin
            div_cnt_r <= '0;
            if (!bus.SCLK) begin
              bus.SCLK <= 1'b1;
            end else begin
              // Falling edge: take the reply bit and present the next transmit bit.
              bus.SCLK <= 1'b0;
              sr_rx_r  <= {sr_rx_r[m-2:0], bus.MISO};
              sr_tx_r  <= {sr_tx_r[m-2:0], 1'b0};
              if (bit_cnt_r == BIT_LAST) begin
                bit_cnt_r <= '0;
                bus.MOSI  <= 1'b0;
                bus.LOAD  <= 1'b1;
                state_r   <= LDP;
              end else begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
                bus.MOSI  <= sr_tx_r[m-2];
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end
        end

        LDP: begin
          if (phase_end_s) begin
            div_cnt_r <= '0;
            if (!bus.SCLK) begin
              bus.SCLK <= 1'b1;
            end else begin
              bus.SCLK    <= 1'b0;
              bus.LOAD    <= 1'b0;
              bus.MRX_DAT <= sr_rx_r;
              bus.DONE    <= 1'b1;
              bus.BUSY    <= 1'b0;
              state_r     <= IDLE;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end
        end

        default: begin
          state_r   <= IDLE;
          div_cnt_r <= '0;
          bit_cnt_r <= '0;
          bus.SCLK  <= 1'b0;
          bus.MOSI  <= 1'b0;
          bus.LOAD  <= 1'b0;
          bus.BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_12.sv
// Scoreboard bench for spi_master_12: a DIV=2 master with a behavioural 12-bit slave and a DIV=1 master.
// Stimulus pushes the expected frame results; negedge monitors pop and compare them on DONE.
module tb_spi_master_12;
  localparam int          M    = 12;
  localparam logic [11:0] S_DI = 12'h3F1;

  typedef struct {
    logic [11:0] mrx;
    logic [11:0] di;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q2[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  // Counts clk rising edges; edge k leaves cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_12_if #(.m(M)) if2();
  spi_master_12_if #(.m(M)) if1();

  spi_master_12 #(.m(M), .DIV(2)) u_div2 (.clk(clk), .clr(clr), .bus(if2));
  spi_master_12 #(.m(M), .DIV(1)) u_div1 (.clk(clk), .clr(clr), .bus(if1));

  // Behavioural slave on the DIV=2 master: registered MISO, latch and reload on the LOAD edge.
  logic [11:0] s_tx = 12'h000, s_rx_sr = 12'h000, s_rx_word = 12'h000;
  logic        s_miso = 1'b0;
  assign if2.MISO = s_miso;
  always @(posedge if2.SCLK) begin
    if (if2.LOAD) begin
      s_rx_word <= s_rx_sr;
      s_tx      <= S_DI;
    end else begin
      s_rx_sr <= {s_rx_sr[10:0], if2.MOSI};
      s_miso  <= s_tx[11];
      s_tx    <= {s_tx[10:0], 1'b0};
    end
  end

  // Receive-only slave on the DIV=1 master.
  logic [11:0] s1_sr = 12'h000, s1_word = 12'h000;
  assign if1.MISO = 1'b0;
  always @(posedge if1.SCLK) begin
    if (if1.LOAD) s1_word <= s1_sr;
    else          s1_sr   <= {s1_sr[10:0], if1.MOSI};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the DIV=2 master.
  int          rises = 0;
  logic [11:0] mosi_sh = 12'h000;
  logic        load_bad = 1'b0, idle_bad = 1'b0, sclk_prev = 1'b0, busy_prev = 1'b0;
  int          t0_meas = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr) begin
        rises = 0; mosi_sh = 12'h000; load_bad = 1'b0; sclk_prev = 1'b0; busy_prev = 1'b0;
      end else begin
        if (if2.BUSY && !busy_prev) t0_meas = cyc;
        if (!if2.BUSY && if2.SCLK) idle_bad = 1'b1;
        if (if2.SCLK && !sclk_prev) begin
          rises++;
          if (rises <= 12) mosi_sh = {mosi_sh[10:0], if2.MOSI};
          if (if2.LOAD != (rises == 13)) load_bad = 1'b1;
        end
        if (if2.LOAD && !((rises == 12 && !if2.SCLK) || rises == 13)) load_bad = 1'b1;
        if (if2.LOAD && if2.MOSI) load_bad = 1'b1;
        if (if2.DONE) begin
          check("done_expected", 32'(q2.size() > 0), 32'd1);
          if (q2.size() > 0) begin
            e = q2.pop_front();
            check("master_mrx", 32'(if2.MRX_DAT), 32'(e.mrx));
            check("slave_rx", 32'(s_rx_word), 32'(e.di));
            check("mosi_bits", 32'(mosi_sh), 32'(e.di));
            check("sclk_rises", 32'(rises), 32'd13);
            check("load_window", 32'(load_bad), 32'd0);
            check("start_cycle", 32'(t0_meas), 32'(e.t0));
            check("done_cycle", 32'(cyc), 32'(e.t0 + 52));
            check("busy_at_done", 32'(if2.BUSY), 32'd0);
          end
          rises = 0; mosi_sh = 12'h000; load_bad = 1'b0;
        end
        sclk_prev = if2.SCLK;
        busy_prev = if2.BUSY;
      end
    end
  end

  // Monitor for the DIV=1 master.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!clr && if1.DONE) begin
        check("div1_done_expected", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("div1_mrx", 32'(if1.MRX_DAT), 32'(e.mrx));
          check("div1_slave_rx", 32'(s1_word), 32'(e.di));
          check("div1_done_cycle", 32'(cyc), 32'(e.t0 + 26));
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start2(input logic [11:0] di, input logic [11:0] mrx);
    exp_t e;
    @(negedge clk);
    if2.ST = 1'b1;
    if2.DI = di;
    e.mrx = mrx; e.di = di; e.t0 = cyc + 1;
    q2.push_back(e);
    @(negedge clk);
    if2.ST = 1'b0;
  endtask

  task automatic wait_idle2();
    for (int i = 0; i < 400 && q2.size() != 0; i++) @(negedge clk);
    check("frame_drain", 32'(q2.size()), 32'd0);
    q2.delete();
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   a;
    if2.ST = 1'b0; if2.DI = 12'h000;
    if1.ST = 1'b0; if1.DI = 12'h000;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({if2.SCLK, if2.MOSI, if2.LOAD, if2.BUSY, if2.DONE, if2.MRX_DAT}), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    // Slave power-up word is zero, then it returns S_DI.
    start2(12'hA5C, 12'h000);
    wait_idle2();
    start2(12'h123, S_DI);
    wait_idle2();

    // ST held high: three frames, each one idle clk apart.
    @(negedge clk);
    a = cyc + 1;
    if2.ST = 1'b1;
    if2.DI = 12'hFFF;
    e.mrx = S_DI; e.di = 12'hFFF; e.t0 = a;       q2.push_back(e);
    e.mrx = S_DI; e.di = 12'h000; e.t0 = a + 53;  q2.push_back(e);
    e.mrx = S_DI; e.di = 12'h800; e.t0 = a + 106; q2.push_back(e);
    wait_cyc(a + 1);
    if2.DI = 12'h000;
    wait_cyc(a + 54);
    if2.DI = 12'h800;
    wait_cyc(a + 107);
    if2.ST = 1'b0;
    wait_idle2();

    // ST pulses during a busy frame are ignored.
    start2(12'h6B2, S_DI);
    for (int i = 0; i < 5; i++) begin
      repeat (7) @(negedge clk);
      if2.ST = 1'b1;
      @(negedge clk);
      if2.ST = 1'b0;
    end
    wait_idle2();
    repeat (4) @(negedge clk);
    check("no_extra_frame", 32'(if2.BUSY), 32'd0);

    // Abort after the 5th rising edge; slave tx has shifted 5 places (0x3F1 -> 0xE20).
    @(negedge clk);
    if2.ST = 1'b1;
    if2.DI = 12'h9E7;
    @(negedge clk);
    if2.ST = 1'b0;
    for (int i = 0; i < 200 && rises < 5; i++) @(negedge clk);
    check("abort_reached_5th_edge", 32'(rises), 32'd5);
    check("abort_busy_before", 32'({if2.BUSY, if2.SCLK, if2.MOSI}), 32'h7);
    #2 clr = 1'b1;
    #1 check("abort_outputs", 32'({if2.SCLK, if2.LOAD, if2.MOSI, if2.BUSY, if2.DONE, if2.MRX_DAT}), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    start2(12'h2C4, 12'hE20);
    wait_idle2();

    // DIV=1 master.
    @(negedge clk);
    if1.ST = 1'b1;
    if1.DI = 12'h555;
    e.mrx = 12'h000; e.di = 12'h555; e.t0 = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    if1.ST = 1'b0;
    for (int i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);

    check("queues_empty", 32'(q2.size() + q1.size()), 32'd0);
    check("sclk_low_when_idle", 32'(idle_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
